// File: rtl/adaptive_threshold_ctrl.sv
// rtl/adaptive_threshold_ctrl.sv - sequencer: box-filter pass, then per-pixel threshold against local mean
module adaptive_threshold_ctrl #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int WIDTH       = 2**WIDTH_BITS,
    parameter int HEIGHT      = 2**HEIGHT_BITS
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    input  logic                   iAbort,
    input  logic [7:0]             iOffset,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oFilterReset,
    input  logic                   iFilterFinished,
    input  logic [WIDTH_BITS-1:0]  iFilterCol,
    input  logic [HEIGHT_BITS-1:0] iFilterRow,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oMeanCol,
    output logic [HEIGHT_BITS-1:0] oMeanRow,
    input  logic [7:0]             iMeanData,
    output logic [WIDTH_BITS-1:0]  oOutCol,
    output logic [HEIGHT_BITS-1:0] oOutRow,
    output logic [7:0]             oOutData,
    output logic                   oOutWren
);

    localparam int PW = WIDTH_BITS + HEIGHT_BITS;
    localparam logic [PW-1:0] LAST_POS = PW'(WIDTH * HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILTER = 3'd1,
        THRESH = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                 state, state_n;
    logic [PW-1:0]          pos, pos_n;
    logic [7:0]             offset_q, offset_n;
    logic                   filt_first, filt_first_n;
    logic [WIDTH_BITS-1:0]  out_col_n;
    logic [HEIGHT_BITS-1:0] out_row_n;
    logic [7:0]             out_data_n;
    logic                   out_wren_n;

    logic [WIDTH_BITS-1:0]  pos_col;
    logic [HEIGHT_BITS-1:0] pos_row;
    logic [8:0]             biased_pixel;
    logic                   above_mean;

    assign pos_col      = pos[WIDTH_BITS-1:0];
    assign pos_row      = pos[PW-1:WIDTH_BITS];
    // Nine bits so image + offset cannot wrap before the compare
    assign biased_pixel = {1'b0, iImageData} + {1'b0, offset_q};
    assign above_mean   = biased_pixel > {1'b0, iMeanData};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pos        <= '0;
            offset_q   <= '0;
            filt_first <= 1'b0;
            oOutCol    <= '0;
            oOutRow    <= '0;
            oOutData   <= '0;
            oOutWren   <= 1'b0;
        end else begin
            state      <= state_n;
            pos        <= pos_n;
            offset_q   <= offset_n;
            filt_first <= filt_first_n;
            oOutCol    <= out_col_n;
            oOutRow    <= out_row_n;
            oOutData   <= out_data_n;
            oOutWren   <= out_wren_n;
        end
    end

    always_comb begin
        state_n      = state;
        pos_n        = pos;
        offset_n     = offset_q;
        filt_first_n = 1'b0;
        out_col_n    = oOutCol;
        out_row_n    = oOutRow;
        out_data_n   = oOutData;
        out_wren_n   = 1'b0;

        unique case (state)
            IDLE: begin
                if (iStart) begin
                    state_n      = FILTER;
                    offset_n     = iOffset;
                    pos_n        = '0;
                    filt_first_n = 1'b1;
                end
            end
            FILTER: begin
                // The filter is still leaving reset on its first cycle, so its finished flag is stale
                if (iAbort) begin
                    state_n = IDLE;
                end else if (iFilterFinished && !filt_first) begin
                    state_n = THRESH;
                    pos_n   = '0;
                end
            end
            THRESH: begin
                if (iAbort) begin
                    state_n = IDLE;
                end else begin
                    out_data_n = above_mean ? 8'd255 : 8'd0;
                    out_col_n  = pos_col;
                    out_row_n  = pos_row;
                    out_wren_n = 1'b1;
                    pos_n      = pos + 1'b1;
                    if (pos == LAST_POS) begin
                        state_n = FLUSH;
                    end
                end
            end
            FLUSH: begin
                state_n = iAbort ? IDLE : DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        oBusy        = (state == FILTER) || (state == THRESH) || (state == FLUSH);
        oDone        = (state == DONE);
        oFilterReset = (state != FILTER);
        oMeanCol     = pos_col;
        oMeanRow     = pos_row;
        oImageCol    = '0;
        oImageRow    = '0;
        if (state == FILTER) begin
            oImageCol = iFilterCol;
            oImageRow = iFilterRow;
        end else if (state == THRESH) begin
            oImageCol = pos_col;
            oImageRow = pos_row;
        end
    end

endmodule

// File: tb/tb_adaptive_threshold_ctrl.sv
// tb/tb_adaptive_threshold_ctrl.sv - self-checking bench for adaptive_threshold_ctrl on a 4x4 frame
module tb_adaptive_threshold_ctrl;

    localparam int WB = 2;
    localparam int HB = 2;
    localparam int NPIX = 16;
    localparam int FILT_LEN = 6;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          iStart = 1'b0;
    logic          iAbort = 1'b0;
    logic [7:0]    iOffset = 8'd0;
    logic          oBusy, oDone, oFilterReset;
    logic          iFilterFinished;
    logic [WB-1:0] iFilterCol;
    logic [HB-1:0] iFilterRow;
    logic [WB-1:0] oImageCol;
    logic [HB-1:0] oImageRow;
    logic [7:0]    iImageData;
    logic [WB-1:0] oMeanCol;
    logic [HB-1:0] oMeanRow;
    logic [7:0]    iMeanData;
    logic [WB-1:0] oOutCol;
    logic [HB-1:0] oOutRow;
    logic [7:0]    oOutData;
    logic          oOutWren;

    logic [7:0] img [NPIX];
    logic [7:0] mean [NPIX];
    int         got [NPIX];
    logic [7:0] cur_off = 8'd0;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int done_cnt = 0;

    logic [3:0] fcnt = 4'd0;
    logic       f_fin = 1'b0;
    logic       stale_hold = 1'b0;

    always #5 clock = ~clock;

    adaptive_threshold_ctrl #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) dut (
        .clock(clock), .reset(reset), .iStart(iStart), .iAbort(iAbort), .iOffset(iOffset),
        .oBusy(oBusy), .oDone(oDone), .oFilterReset(oFilterReset),
        .iFilterFinished(iFilterFinished), .iFilterCol(iFilterCol), .iFilterRow(iFilterRow),
        .oImageCol(oImageCol), .oImageRow(oImageRow), .iImageData(iImageData),
        .oMeanCol(oMeanCol), .oMeanRow(oMeanRow), .iMeanData(iMeanData),
        .oOutCol(oOutCol), .oOutRow(oOutRow), .oOutData(oOutData), .oOutWren(oOutWren)
    );

    assign iImageData      = img[{oImageRow, oImageCol}];
    assign iMeanData       = mean[{oMeanRow, oMeanCol}];
    assign iFilterFinished = f_fin | stale_hold;
    assign iFilterCol      = fcnt[1:0];
    assign iFilterRow      = fcnt[3:2];

    // Stand-in filter stage: synchronous reset, finishes a fixed number of cycles after release
    always @(posedge clock) begin
        if (oFilterReset) begin
            fcnt  <= 4'd0;
            f_fin <= 1'b0;
        end else if (fcnt == 4'(FILT_LEN - 1)) begin
            f_fin <= 1'b1;
        end else begin
            fcnt <= fcnt + 4'd1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_pix(input int p);
        return (int'(img[p]) + int'(cur_off) > int'(mean[p])) ? 255 : 0;
    endfunction

    always @(negedge clock) begin
        if (reset && oOutWren) begin
            int p;
            p = int'({oOutRow, oOutCol});
            check("wr_addr", p, wr_cnt);
            check("wr_data", int'(oOutData), exp_pix(p));
            got[p] = int'(oOutData);
            wr_cnt++;
        end
        if (oDone) done_cnt++;
    end

    task automatic run(input logic [7:0] off, input int abort_pos, input bit stale,
                       input bit poke, input int rst_pos, input int exp_writes);
        int  cyc;
        int  abort_cyc;
        bit  fin;
        bit  normal;
        int  pos;
        normal = (abort_pos < 0) && (rst_pos < 0);
        @(negedge clock); #1;
        wr_cnt = 0; done_cnt = 0;
        cur_off = off; iOffset = off; iStart = 1'b1; stale_hold = stale;
        cyc = 0; fin = 1'b0; abort_cyc = -1;
        while (!fin && cyc < 100) begin
            @(negedge clock); #1;
            cyc++;
            iStart = 1'b0;
            iAbort = 1'b0;
            pos = int'({oMeanRow, oMeanCol});
            if (cyc == 1) begin
                check("busy_on_entry", int'(oBusy), 1);
                check("freset_in_filter", int'(oFilterReset), 0);
            end
            if (cyc == 2) begin
                if (stale) check("stale_ignored", int'(oFilterReset), 0);
                stale_hold = 1'b0;
            end
            if (!oFilterReset)
                check("img_mux_filter", int'({oImageRow, oImageCol}), int'({iFilterRow, iFilterCol}));
            if (poke && cyc == 3) iStart = 1'b1;
            if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                check("abort_wren", int'(oOutWren), 0);
                check("abort_busy", int'(oBusy), 0);
                check("abort_freset", int'(oFilterReset), 1);
                fin = 1'b1;
            end else if (abort_pos >= 0 && abort_cyc < 0 && oBusy && oFilterReset && pos == abort_pos) begin
                iAbort = 1'b1;
                abort_cyc = cyc;
            end
            if (rst_pos >= 0 && oBusy && oFilterReset && pos == rst_pos) begin
                #2 reset = 1'b0;
                #1;
                check("rst_wren", int'(oOutWren), 0);
                check("rst_busy", int'(oBusy), 0);
                check("rst_freset", int'(oFilterReset), 1);
                check("rst_done", int'(oDone), 0);
                @(negedge clock); #1;
                reset = 1'b1;
                fin = 1'b1;
            end
            if (oDone) begin
                check("run_length", cyc, 7 + NPIX + 2);
                check("busy_in_done", int'(oBusy), 0);
                if (poke) iStart = 1'b1;
                fin = 1'b1;
            end
        end
        check("run_terminated", int'(fin), 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock); #1;
            iStart = 1'b0;
            check("idle_after_run", int'(oBusy), 0);
        end
        check("done_count", done_cnt, normal ? 1 : 0);
        check("write_count", wr_cnt, exp_writes);
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) begin
            img[i] = 8'd100; mean[i] = 8'd100; got[i] = -1;
        end
        #12;
        check("rst_busy0", int'(oBusy), 0);
        check("rst_done0", int'(oDone), 0);
        check("rst_wren0", int'(oOutWren), 0);
        check("rst_data0", int'(oOutData), 0);
        check("rst_outaddr0", int'({oOutRow, oOutCol}), 0);
        check("rst_freset0", int'(oFilterReset), 1);
        @(negedge clock);
        reset = 1'b1;

        run(8'd0, -1, 1'b0, 1'b0, -1, 16);
        check("uniform_off0_p0", got[0], 0);
        check("uniform_off0_p15", got[15], 0);

        run(8'd1, -1, 1'b0, 1'b0, -1, 16);
        check("uniform_off1_p7", got[7], 255);

        for (int i = 0; i < NPIX; i++) begin
            img[i] = 8'd255; mean[i] = 8'd255;
        end
        img[0] = 8'd0;
        run(8'd255, -1, 1'b0, 1'b0, -1, 16);
        check("edge_nowrap_p15", got[15], 255);
        check("edge_equal_p0", got[0], 0);

        for (int i = 0; i < NPIX; i++) begin
            img[i] = 8'(i * 16); mean[i] = 8'd128;
        end
        run(8'd8, -1, 1'b1, 1'b1, -1, 16);
        check("ramp_p7", got[7], 0);
        check("ramp_p8", got[8], 255);

        run(8'd8, 5, 1'b0, 1'b0, -1, 5);
        run(8'd8, -1, 1'b0, 1'b0, -1, 16);
        run(8'd8, -1, 1'b0, 1'b0, 8, 8);
        run(8'd0, -1, 1'b0, 1'b0, -1, 16);
        check("post_reset_p9", got[9], 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
